// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction/load-store memory port arbiter:
// FSM state encodings and the streak-counter width helper.
package imem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_GRANT_IF = 3'd1,
    ARB_GRANT_LS = 3'd2,
    ARB_DONE     = 3'd3,
    ARB_ERR_LS   = 3'd4
  } arb_state_t;

  localparam int unsigned DEF_MAX_STREAK = 4;

  // Width needed to hold 0..max_streak inclusive.
  function automatic int unsigned streak_w(input int unsigned max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_arb_pick.sv
// Combinational winner select for one IDLE cycle: misaligned LS beats IF,
// otherwise LS wins unless IF has waited MAX_STREAK consecutive LS grants.
module arb_pick
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK,
  parameter int unsigned SW         = streak_w(DEF_MAX_STREAK)
) (
  input  logic          ls_req,
  input  logic          if_req,
  input  logic [SW-1:0] streak,
  input  logic          misalign,
  output logic          sel_if,
  output logic          sel_ls,
  output logic          sel_err
);

  logic if_turn;

  always_comb begin
    if_turn = (streak == SW'(MAX_STREAK));
    sel_err = ls_req & misalign;
    sel_ls  = ls_req & ~misalign & (~if_req | ~if_turn);
    sel_if  = if_req & ~sel_err & ~sel_ls;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one req/ack memory port between fetch and load/store, one transaction at a time.
// Zero-wait memory: request cycle N -> mem_req N+1 -> *_done N+2; mem_req holds until mem_ack.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                fetch_stall,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned SW = streak_w(MAX_STREAK);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] streak;
  logic          if_cand, ls_cand;
  logic          sel_if, sel_ls, sel_err;
  logic          grant_if, grant_ls, err_go, ack_if, ack_ls;

  // A requester still showing its done pulse is not a fresh request.
  assign if_cand = if_req & ~if_done;
  assign ls_cand = ls_req & ~ls_done;

  arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .ls_req   (ls_cand),
    .if_req   (if_cand),
    .streak   (streak),
    .misalign (ls_addr[1:0] != 2'b00),
    .sel_if   (sel_if),
    .sel_ls   (sel_ls),
    .sel_err  (sel_err)
  );

  assign grant_if = (state == ARB_IDLE) & sel_if;
  assign grant_ls = (state == ARB_IDLE) & sel_ls;
  assign err_go   = (state == ARB_IDLE) & sel_err;
  assign ack_if   = (state == ARB_GRANT_IF) & mem_ack;
  assign ack_ls   = (state == ARB_GRANT_LS) & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (sel_err)     state_nxt = ARB_ERR_LS;
        else if (sel_ls) state_nxt = ARB_GRANT_LS;
        else if (sel_if) state_nxt = ARB_GRANT_IF;
      end
      ARB_GRANT_IF, ARB_GRANT_LS: if (mem_ack) state_nxt = ARB_DONE;
      ARB_DONE, ARB_ERR_LS:       state_nxt = ARB_IDLE;
      default:                    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      if_done     <= 1'b0;
      if_rdata    <= '0;
      fetch_stall <= 1'b1;
      ls_done     <= 1'b0;
      ls_rdata    <= '0;
      ls_err      <= 1'b0;
    end else begin
      if_done     <= ack_if;
      fetch_stall <= ~ack_if;
      ls_done     <= ack_ls | err_go;
      ls_err      <= err_go;
      if (ack_if) if_rdata <= mem_rdata;
      // Stores and misaligned accesses return zero data.
      if (ack_ls)      ls_rdata <= mem_we ? '0 : mem_rdata;
      else if (err_go) ls_rdata <= '0;
      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (grant_ls) begin
        mem_req   <= 1'b1;
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_be    <= ls_be;
      end else if (ack_if | ack_ls) begin
        mem_req   <= 1'b0;
      end
    end
  end

  // Counts LS grants that overtook a waiting fetch; saturates so IF wins next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      streak <= '0;
    else if (!if_req || grant_if)                    streak <= '0;
    else if (grant_ls && streak != SW'(MAX_STREAK))  streak <= streak + SW'(1);
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: memory responder with programmable ack delay,
// done-side scoreboard, vector table plus hand-written multi-cycle sequences.
module tb_imem_port_arbiter;
  import imem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_done, fetch_stall;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_done, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .fetch_stall(fetch_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return 32'h1234_5678 ^ a;
  endfunction

  // Memory responder: acks after ack_delay extra cycles; stray acks on request.
  int ack_delay = 0;
  int wcnt = 0;
  int stray_req = 0;
  int stray_done = 0;
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    if (stray_req != stray_done) begin
      mem_ack    = 1'b1;
      mem_rdata  = 32'hDEAD_0000;
      stray_done = stray_req;
      wcnt       = 0;
    end else if (mem_req) begin
      if (wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model(mem_addr);
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  typedef struct packed { logic [31:0] rdata; logic err; } ls_exp_t;
  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_mcyc;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ifq[$];
  ls_exp_t     lsq[$];
  logic [31:0] grants[$];
  logic        mreq_prev = 1'b0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and score any done pulse.
  task automatic tick();
    logic [31:0] e;
    ls_exp_t     le;
    @(posedge clk);
    #1;
    if (mem_req && !mreq_prev) grants.push_back(mem_addr);
    mreq_prev = mem_req;
    if (if_done) begin
      chk("fetch_stall_on_done", 32'(fetch_stall), 32'd0);
      if (ifq.size() == 0) chk("spurious_if_done", 32'(if_done), 32'd0);
      else begin
        e = ifq.pop_front();
        chk("if_rdata", if_rdata, e);
      end
    end else begin
      chk("fetch_stall_held", 32'(fetch_stall), 32'd1);
    end
    if (ls_done) begin
      if (lsq.size() == 0) chk("spurious_ls_done", 32'(ls_done), 32'd0);
      else begin
        le = lsq.pop_front();
        chk("ls_rdata", ls_rdata, le.rdata);
        chk("ls_err", 32'(ls_err), 32'(le.err));
      end
    end
  endtask

  function automatic vec_t mkv(input bit is_ls, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int delay);
    vec_t v;
    v.is_ls     = is_ls;
    v.we        = we;
    v.addr      = addr;
    v.wdata     = wdata;
    v.be        = be;
    v.delay     = delay;
    v.exp_err   = is_ls && (addr[1:0] != 2'b00);
    v.exp_rdata = (v.exp_err || we) ? 32'h0 : mem_model(addr);
    v.exp_lat   = v.exp_err ? 1 : delay + 2;
    v.exp_mcyc  = v.exp_err ? 0 : delay + 1;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   lat, mcyc, mbad, gi;
    bit   got;
    logic [31:0] exp_a;

    vecs[0] = mkv(1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'hF,    0);
    vecs[1] = mkv(1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'hF,    1);
    vecs[2] = mkv(1'b1, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 3);
    vecs[3] = mkv(1'b1, 1'b0, 32'h0000_0102, 32'h0,         4'hF,    0);
    vecs[4] = mkv(1'b1, 1'b1, 32'h0000_0021, 32'h5555_AAAA, 4'hF,    0);
    vecs[5] = mkv(1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF,    2);
    vecs[6] = mkv(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF,    0);
    vecs[7] = mkv(1'b1, 1'b0, 32'h0000_0003, 32'h0,         4'hF,    1);

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;

    // Reset state
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_ls_err", 32'(ls_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("rst_streak", 32'(dut.streak), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // IF only, zero-wait: mem_req at N+1, if_done with data at N+2
    ack_delay = 0;
    if_addr = 32'h0; if_req = 1'b1;
    ifq.push_back(32'h1234_5678);
    tick();
    chk("t2_mem_req_n1", 32'(mem_req), 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h0);
    tick();
    chk("t2_if_done_n2", 32'(if_done), 32'd1);
    chk("t2_if_rdata", if_rdata, 32'h1234_5678);
    chk("t2_fetch_stall_low", 32'(fetch_stall), 32'd0);
    if_req = 1'b0;
    tick();
    chk("t2_if_done_drop", 32'(if_done), 32'd0);
    chk("t2_fetch_stall_back", 32'(fetch_stall), 32'd1);
    tick();

    // Reset mid-GRANT_LS drops mem_req immediately and discards the access
    ack_delay = 6;
    ls_addr = 32'h0000_0300; ls_we = 1'b0; ls_be = 4'hF; ls_req = 1'b1;
    for (int k = 0; k < 10 && !mem_req; k++) tick();
    chk("t1_mem_req_up", 32'(mem_req), 32'd1);
    chk("t1_state_grant_ls", 32'(dut.state), 32'(ARB_GRANT_LS));
    #2 rst_n = 1'b0;
    #1;
    chk("t1_mem_req_async", 32'(mem_req), 32'd0);
    chk("t1_fetch_stall", 32'(fetch_stall), 32'd1);
    ls_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_state_idle", 32'(dut.state), 32'(ARB_IDLE));
    mcyc = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_req) mcyc++;
    end
    chk("t1_no_mem_req_after", 32'(mcyc), 32'd0);

    // Vector table: single transactions, latency / mem_* stability / data
    foreach (vecs[i]) begin
      v = vecs[i];
      ack_delay = v.delay;
      if (v.is_ls) begin
        ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_be = v.be; ls_req = 1'b1;
        lsq.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      end else begin
        if_addr = v.addr; if_req = 1'b1;
        ifq.push_back(v.exp_rdata);
      end
      lat = 0; mcyc = 0; mbad = 0; got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
        tick();
        if (mem_req) begin
          mcyc++;
          if (mem_addr !== v.addr || mem_we !== v.we ||
              (v.is_ls && (mem_wdata !== v.wdata || mem_be !== v.be))) mbad++;
        end
        if (v.is_ls ? ls_done : if_done) begin
          got = 1'b1; lat = k; ls_req = 1'b0; if_req = 1'b0;
        end
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_mem_req_cycles", i), 32'(mcyc), 32'(v.exp_mcyc));
      chk($sformatf("v%0d_mem_stable", i), 32'(mbad), 32'd0);
      tick();
      tick();
    end

    // Both request continuously: LS x4, IF, LS x4, IF
    ack_delay = 0;
    grants.delete();
    gi = 0;
    for (int j = 0; j < 8; j++) lsq.push_back('{rdata: mem_model(32'h0000_0800), err: 1'b0});
    for (int j = 0; j < 2; j++) ifq.push_back(mem_model(32'h0000_0040));
    if_addr = 32'h0000_0040; ls_addr = 32'h0000_0800; ls_we = 1'b0; ls_be = 4'hF;
    if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 200 && gi < 10; k++) begin
      tick();
      while (gi < grants.size() && gi < 10) begin
        exp_a = (gi % 5 == 4) ? 32'h0000_0040 : 32'h0000_0800;
        chk($sformatf("t3_grant%0d", gi), grants[gi], exp_a);
        chk($sformatf("t3_streak%0d", gi), 32'(dut.streak),
            (gi % 5 == 4) ? 32'd0 : 32'((gi % 5) + 1));
        gi++;
      end
    end
    chk("t3_grant_count", 32'(gi), 32'd10);
    if_req = 1'b0; ls_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Stray ack in IDLE; then if_req held through its done cycle
    stray_req++;
    tick();
    tick();
    chk("t6_stray_mem_req", 32'(mem_req), 32'd0);
    chk("t6_stray_state", 32'(dut.state), 32'(ARB_IDLE));
    ack_delay = 1;
    if_addr = 32'h0000_0080; if_req = 1'b1;
    ifq.push_back(mem_model(32'h0000_0080));
    for (int k = 0; k < 20 && !if_done; k++) tick();
    chk("t6_if_done", 32'(if_done), 32'd1);
    tick();
    chk("t6_no_dup_grant", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    mcyc = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_req) mcyc++;
    end
    chk("t6_quiet_after", 32'(mcyc), 32'd0);

    chk("if_queue_drained", 32'(ifq.size()), 32'd0);
    chk("ls_queue_drained", 32'(lsq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
